// File: rtl/fetch_ctrl_risk_if.sv
// rtl/fetch_ctrl_risk_if.sv - fetch controller bus bundle (PC, memory, decode)
//
// Purpose: groups the PC-enable, instruction-memory req/ack and decode valid/ready
//          signals of fetch_ctrl_risk into one bundle.
// Ports (signals):
//   i_pc        PC register q            o_pc_en     PC register enable
//   o_mem_req   memory read request      o_mem_addr  memory read address
//   i_mem_ack   read done                i_mem_rdata instruction word
//   o_valid     word valid to decode     o_instr     fetched instruction
//   o_instr_pc  PC of o_instr            i_ready     decode accepts
//   i_flush     taken branch/jump
// Modports: master = fetch controller, slave = surrounding pipeline/memory.
interface fetch_ctrl_risk_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] i_pc;
    logic              o_pc_en;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_valid;
    logic [DATA_W-1:0] o_instr;
    logic [ADDR_W-1:0] o_instr_pc;
    logic              i_ready;
    logic              i_flush;

    modport master (
        input  i_pc, i_mem_ack, i_mem_rdata, i_ready, i_flush,
        output o_pc_en, o_mem_req, o_mem_addr, o_valid, o_instr, o_instr_pc
    );

    modport slave (
        output i_pc, i_mem_ack, i_mem_rdata, i_ready, i_flush,
        input  o_pc_en, o_mem_req, o_mem_addr, o_valid, o_instr, o_instr_pc
    );
endinterface

// File: rtl/fetch_ctrl_risk.sv
// rtl/fetch_ctrl_risk.sv - instruction fetch controller with 1-entry skid buffer
//
// Purpose: reads the instruction at the current PC over a req/ack memory port,
//          presents {instr, pc} to decode over valid/ready, and enables the PC
//          register only when a fetch is accepted. Flushes on taken branch/jump.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    fetch_ctrl_risk_if.master (PC enable, memory req/ack, decode valid/ready,
//          flush)
module fetch_ctrl_risk #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = 32'h0000_0013
) (
    input  logic                i_clk,
    input  logic                i_rst,
    fetch_ctrl_risk_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SKID  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              pc_en;
    logic              slot_free;

    assign slot_free = !valid_q || bus.i_ready;

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        pc_en        = 1'b0;

        // Word currently on the output is consumed by decode.
        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d    = REQ;
                mem_addr_d = bus.i_pc;
            end
            REQ: begin
                // Track the live PC so a flush can freeze the outstanding address.
                mem_addr_d = bus.i_pc;
                if (bus.i_mem_ack) begin
                    pc_en = 1'b1;
                    if (slot_free) begin
                        valid_d    = 1'b1;
                        instr_d    = bus.i_mem_rdata;
                        instr_pc_d = bus.i_pc;
                    end else begin
                        skid_instr_d = bus.i_mem_rdata;
                        skid_pc_d    = bus.i_pc;
                        state_d      = SKID;
                    end
                end
            end
            SKID: begin
                if (bus.i_ready) begin
                    valid_d    = 1'b1;
                    instr_d    = skid_instr_q;
                    instr_pc_d = skid_pc_q;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                // Returning word belongs to the squashed path; discard it.
                if (bus.i_mem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over all of the above. The PC loads the target at this edge,
        // so a pending un-acked request must be drained at its old address.
        if (bus.i_flush) begin
            pc_en      = 1'b1;
            valid_d    = 1'b0;
            instr_d    = NOP_VAL;
            instr_pc_d = instr_pc_q;
            if ((state_q == REQ || state_q == DRAIN) && !bus.i_mem_ack) begin
                state_d = DRAIN;
            end else begin
                state_d = REQ;
            end
        end

        mem_req_d = (state_d == REQ) || (state_d == DRAIN);

        if (i_rst) begin
            pc_en = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_VAL;
            instr_pc_q   <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // In REQ the address comes straight from the PC register q. The PC only moves
    // when o_pc_en is high (ack or flush), so it is stable for the whole request,
    // and this is what allows a new request every cycle right after an ack.
    // DRAIN uses the frozen copy because the PC has already jumped to the target.
    assign bus.o_mem_addr = (state_q == REQ) ? bus.i_pc : mem_addr_q;
    assign bus.o_mem_req  = mem_req_q;
    assign bus.o_pc_en    = pc_en;
    assign bus.o_valid    = valid_q;
    assign bus.o_instr    = instr_q;
    assign bus.o_instr_pc = instr_pc_q;
endmodule

// File: tb/tb_fetch_ctrl_risk.sv
// tb/tb_fetch_ctrl_risk.sv - directed vector bench for fetch_ctrl_risk
module tb_fetch_ctrl_risk;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc  = 32'h0;
    logic [31:0] tgt = 32'h0;
    int          total = 0;
    int          bad   = 0;

    fetch_ctrl_risk_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    fetch_ctrl_risk #(.ADDR_W(32), .DATA_W(32), .NOP_VAL(NOP)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign bif.i_pc        = pc;
    assign bif.i_mem_rdata = bif.i_mem_ack ? mkdata(bif.o_mem_addr) : 32'hDEAD_BEEF;

    // PC register model: +4 on accepted fetch, branch target on flush.
    always @(posedge clk) begin
        if (bif.o_pc_en) pc <= bif.i_flush ? tgt : pc + 32'd4;
    end

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        fl;
        logic [31:0] tg;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic        e_nop;
        logic        e_pcen;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: checks registered outputs, drives inputs, checks o_pc_en.
    task automatic apply(input int idx, input vec_t v);
        string s;
        s = $sformatf("row%0d", idx);
        chk({s, ".req"}, {31'd0, bif.o_mem_req}, {31'd0, v.e_req});
        if (v.e_req) chk({s, ".addr"}, bif.o_mem_addr, v.e_addr);
        chk({s, ".valid"}, {31'd0, bif.o_valid}, {31'd0, v.e_valid});
        if (v.e_valid) begin
            chk({s, ".ipc"}, bif.o_instr_pc, v.e_ipc);
            chk({s, ".instr"}, bif.o_instr, mkdata(v.e_ipc));
        end
        if (v.e_nop) chk({s, ".nop"}, bif.o_instr, NOP);
        bif.i_mem_ack = v.ack;
        bif.i_ready   = v.rdy;
        bif.i_flush   = v.fl;
        tgt           = v.tg;
        #1;
        chk({s, ".pc_en"}, {31'd0, bif.o_pc_en}, {31'd0, v.e_pcen});
        @(negedge clk);
    endtask

    initial begin
        bif.i_mem_ack = 1'b0;
        bif.i_ready   = 1'b1;
        bif.i_flush   = 1'b0;

        //            ack rdy fl tgt       req addr      vld ipc       nop pcen
        // 1: single-cycle ack stream 0x0,0x4,0x8,0xC
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,   1'b0,32'h0,  1'b0,32'h0,  1'b1,1'b0});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h0,  1'b0,32'h0,  1'b1,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h4,  1'b1,32'h0,  1'b0,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h8,  1'b1,32'h4,  1'b0,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'hC,  1'b1,32'h8,  1'b0,1'b1});
        // 2: ack held off 3 cycles at 0x10
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h10, 1'b1,32'hC,  1'b0,1'b0});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h10, 1'b0,32'h0,  1'b0,1'b0});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h10, 1'b0,32'h0,  1'b0,1'b0});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h10, 1'b0,32'h0,  1'b0,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h14, 1'b1,32'h10, 1'b0,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h18, 1'b1,32'h14, 1'b0,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h1C, 1'b1,32'h18, 1'b0,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h20, 1'b1,32'h1C, 1'b0,1'b1});
        // 3: decode stalls 4 cycles with 0x20 on output, 0x24 goes to skid
        vq.push_back('{1'b1,1'b0,1'b0,32'h0,   1'b1,32'h24, 1'b1,32'h20, 1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,  1'b1,32'h20, 1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,  1'b1,32'h20, 1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,  1'b1,32'h20, 1'b0,1'b0});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,   1'b0,32'h0,  1'b1,32'h20, 1'b0,1'b0});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h28, 1'b1,32'h24, 1'b0,1'b0});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h28, 1'b0,32'h0,  1'b0,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h2C, 1'b1,32'h28, 1'b0,1'b1});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h30, 1'b1,32'h2C, 1'b0,1'b0});
        // 4: flush with 0x30 un-acked, target 0x100 -> drain, drop, refetch
        vq.push_back('{1'b0,1'b1,1'b1,32'h100, 1'b1,32'h30, 1'b0,32'h0,  1'b0,1'b1});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h30, 1'b0,32'h0,  1'b1,1'b0});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h30, 1'b0,32'h0,  1'b1,1'b0});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h100,1'b0,32'h0,  1'b1,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h104,1'b1,32'h100,1'b0,1'b1});
        // 5: fill skid, flush it; then flush coincident with ack
        vq.push_back('{1'b1,1'b0,1'b0,32'h0,   1'b1,32'h108,1'b1,32'h104,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,1'b1,32'h200, 1'b0,32'h0,  1'b1,32'h104,1'b0,1'b1});
        vq.push_back('{1'b1,1'b1,1'b1,32'h300, 1'b1,32'h200,1'b0,32'h0,  1'b1,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h300,1'b0,32'h0,  1'b1,1'b1});
        // flush together with i_ready, request pending -> drain 0x304
        vq.push_back('{1'b0,1'b1,1'b1,32'h40,  1'b1,32'h304,1'b1,32'h300,1'b0,1'b1});
        vq.push_back('{1'b1,1'b1,1'b0,32'h0,   1'b1,32'h304,1'b0,32'h0,  1'b1,1'b0});
        vq.push_back('{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h40, 1'b0,32'h0,  1'b1,1'b0});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.req",   {31'd0, bif.o_mem_req}, 32'd0);
        chk("rst.valid", {31'd0, bif.o_valid},   32'd0);
        chk("rst.pc_en", {31'd0, bif.o_pc_en},   32'd0);
        chk("rst.addr",  bif.o_mem_addr,          32'd0);
        chk("rst.instr", bif.o_instr,             NOP);
        chk("rst.ipc",   bif.o_instr_pc,          32'd0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

        // 6: reset while request 0x40 is outstanding, stray acks during/after reset
        rst = 1'b1;
        bif.i_mem_ack = 1'b1;
        #1;
        chk("r6.req",   {31'd0, bif.o_mem_req}, 32'd0);
        chk("r6.valid", {31'd0, bif.o_valid},   32'd0);
        chk("r6.pc_en", {31'd0, bif.o_pc_en},   32'd0);
        chk("r6.addr",  bif.o_mem_addr,          32'd0);
        chk("r6.instr", bif.o_instr,             NOP);
        chk("r6.ipc",   bif.o_instr_pc,          32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("r6.idle_req",   {31'd0, bif.o_mem_req}, 32'd0);
        chk("r6.idle_pc_en", {31'd0, bif.o_pc_en},   32'd0);
        @(negedge clk);
        bif.i_mem_ack = 1'b0;
        chk("r6.req1",   {31'd0, bif.o_mem_req}, 32'd1);
        chk("r6.addr1",  bif.o_mem_addr,          32'h40);
        chk("r6.valid1", {31'd0, bif.o_valid},   32'd0);
        chk("r6.pc",     pc,                      32'h40);
        bif.i_mem_ack = 1'b1;
        #1;
        chk("r6.pc_en1", {31'd0, bif.o_pc_en}, 32'd1);
        @(negedge clk);
        bif.i_mem_ack = 1'b0;
        chk("r6.valid2", {31'd0, bif.o_valid}, 32'd1);
        chk("r6.ipc2",   bif.o_instr_pc,        32'h40);
        chk("r6.instr2", bif.o_instr,           mkdata(32'h40));
        chk("r6.addr2",  bif.o_mem_addr,        32'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
